// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency ALU.
// Holds one operation at a time from accept through the response handshake.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_fun,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_arith_out,
    input  logic [WIDTH-1:0] alu_logic_out,
    input  logic [WIDTH-1:0] alu_cmp_out,
    input  logic [WIDTH-1:0] alu_shift_out,
    input  logic             alu_arith_flag,
    input  logic             alu_logic_flag,
    input  logic             alu_cmp_flag,
    input  logic             alu_shift_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic       last_grant_reg;

    logic             in_idle;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_flag;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        in_idle  = rst && (state_reg == IDLE);
        grant_id = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
        accept   = in_idle && (req0_valid || req1_valid);
    end

    assign req0_ready = in_idle && req0_valid && !grant_id;
    assign req1_ready = in_idle && req1_valid && grant_id;

    always_comb begin
        sel_data = alu_arith_out;
        sel_flag = alu_arith_flag;
        case (alu_fun[3:2])
            2'b00: begin
                sel_data = alu_arith_out;
                sel_flag = alu_arith_flag;
            end
            2'b01: begin
                sel_data = alu_logic_out;
                sel_flag = alu_logic_flag;
            end
            2'b10: begin
                sel_data = alu_cmp_out;
                sel_flag = alu_cmp_flag;
            end
            default: begin
                sel_data = alu_shift_out;
                sel_flag = alu_shift_flag;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            last_grant_reg <= 1'b1;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_fun        <= 4'd0;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_data       <= '0;
            rsp_flag       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a          <= grant_id ? req1_a : req0_a;
                        alu_b          <= grant_id ? req1_b : req0_b;
                        alu_fun        <= grant_id ? req1_fun : req0_fun;
                        rsp_id         <= grant_id;
                        last_grant_reg <= grant_id;
                        cnt_reg        <= 3'(ALU_LAT);
                        busy           <= 1'b1;
                        state_reg      <= WAIT;
                    end
                end
                WAIT: begin
                    // Capture on the edge after the counter has reached zero.
                    if (cnt_reg == 3'd0) begin
                        rsp_data  <= sel_data;
                        rsp_flag  <= sel_flag;
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared-ALU ports.
module tb_alu_arbiter;

    localparam int WIDTH   = 16;
    localparam int ALU_LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_fun, req1_fun;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out;
    logic             alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
    logic [WIDTH-1:0] rsp_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out),
        .alu_cmp_out(alu_cmp_out), .alu_shift_out(alu_shift_out),
        .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
        .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every group produces a distinct result so a wrong group select is visible.
    always_comb begin
        case (alu_fun[1:0])
            2'b00:   alu_arith_out = alu_a + alu_b;
            2'b01:   alu_arith_out = alu_a - alu_b;
            2'b10:   alu_arith_out = alu_a * alu_b;
            default: alu_arith_out = -alu_a;
        endcase
        case (alu_fun[1:0])
            2'b00:   alu_logic_out = alu_a & alu_b;
            2'b01:   alu_logic_out = alu_a | alu_b;
            2'b10:   alu_logic_out = alu_a ^ alu_b;
            default: alu_logic_out = ~alu_a;
        endcase
        case (alu_fun[1:0])
            2'b00, 2'b01: alu_shift_out = alu_a << alu_b[3:0];
            2'b10:        alu_shift_out = alu_a >> alu_b[3:0];
            default:      alu_shift_out = $signed(alu_a) >>> alu_b[3:0];
        endcase
        alu_cmp_flag   = $signed(alu_a) < $signed(alu_b);
        alu_cmp_out    = alu_cmp_flag ? 16'h00C1 : 16'h00C0;
        alu_arith_flag = (alu_arith_out == '0);
        alu_logic_flag = alu_logic_out[0];
        alu_shift_flag = alu_a[WIDTH-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] fun);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = fun;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = fun;
        end
    endtask

    // Called just after the accept edge; counts edges until rsp_valid appears.
    task automatic await_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input bit id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [3:0] fun,
                          input logic [WIDTH-1:0] exp_data, input logic exp_flag);
        int lat;
        drive(id, a, b, fun);
        #1;
        chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        await_rsp(lat);
        chk({tag, "_lat"}, lat, ALU_LAT + 1);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_flag"}, rsp_flag, exp_flag);
        chk({tag, "_id"}, rsp_id, id);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_done"}, {rsp_valid, busy}, 0);
        $display("op %s id=%0d a=%0d b=%0d fun=%b -> data=%0h flag=%0d", tag, id, a, b, fun,
                 rsp_data, rsp_flag);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        int prev_acc;
        int acc;
        bit gid;

        rst = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 16'd10; req0_b = 16'd5; req0_fun = 4'b0000;
        req1_a = '0; req1_b = '0; req1_fun = 4'b0000;

        // Reset state, with a requester already valid.
        repeat (2) tick();
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_a, alu_b, alu_fun}, 0);
        chk("rst_rsp", {rsp_id, rsp_data, rsp_flag}, 0);
        $display("reset checked");

        // Single ADD from req0.
        rst = 1'b1;
        #1;
        chk("add_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        chk("add_busy", busy, 1);
        chk("add_alu", {alu_a, alu_b, alu_fun}, {16'd10, 16'd5, 4'b0000});
        chk("add_wait_ready", {req0_ready, req1_ready}, 0);
        await_rsp(lat);
        chk("add_lat", lat, ALU_LAT + 1);
        chk("add_data", rsp_data, 15);
        chk("add_id", rsp_id, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("add_done", {rsp_valid, busy}, 0);
        $display("op add id=0 -> lat=%0d data=%0d", lat, rsp_data);

        // Tie straight after reset: req0 SUB first, then req1 MUL.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(0, 16'd10, 16'd5, 4'b0001);
        drive(1, 16'd3, 16'd4, 4'b0010);
        #1;
        chk("tie_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        await_rsp(lat);
        chk("tie_sub_data", rsp_data, 5);
        chk("tie_sub_id", rsp_id, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tie_mul_ready", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 1'b0;
        await_rsp(lat);
        chk("tie_mul_data", rsp_data, 12);
        chk("tie_mul_id", rsp_id, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        $display("op tie -> sub then mul, last data=%0d", rsp_data);

        // Compare op whose response is stalled for 5 cycles while req1 waits.
        drive(0, 16'd7, 16'd11, 4'b1011);
        #1;
        tick();
        req0_valid = 1'b0;
        drive(1, 16'd100, 16'd200, 4'b0000);
        await_rsp(lat);
        chk("cmp_data", rsp_data, 16'h00C1);
        chk("cmp_flag", rsp_flag, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flag}, {1'b1, 1'b0, 16'h00C1, 1'b1});
            chk("hold_ready", {req0_ready, req1_ready}, 0);
            chk("hold_busy", busy, 1);
            chk("hold_alu_a", alu_a, 7);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hs_no_accept", {rsp_valid, busy, alu_a}, {2'b00, 16'd7});
        chk("hs_idle_ready", req1_ready, 1);
        req1_valid = 1'b0;
        $display("op cmp stall -> data=%0h held 5 cycles", rsp_data);

        run_op("shift", 0, 16'd4, 16'd1, 4'b1100, 16'd8, 1'b0);
        run_op("logic", 1, 16'd6, 16'd3, 4'b0110, 16'd5, 1'b1);
        run_op("nop", 0, 16'd1, 16'd2, 4'b1000, 16'h00C1, 1'b1);

        // Reset during WAIT abandons the operation.
        drive(0, 16'd20, 16'd22, 4'b0000);
        #1;
        tick();
        req0_valid = 1'b0;
        chk("abort_busy_pre", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_async", {rsp_valid, busy, alu_a}, 0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        $display("reset in WAIT -> stale responses=%0d", seen);

        // Both held valid continuously: strict alternation at full throughput.
        drive(0, 16'd1, 16'd2, 4'b0000);
        drive(1, 16'd9, 16'd4, 4'b0001);
        rsp_ready = 1'b1;
        #1;
        chk("rr_first_ready", {req0_ready, req1_ready}, 2'b10);
        prev_acc = 0;
        for (int op = 0; op < 4; op++) begin
            lat = 0;
            while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && lat < 20) begin
                tick();
                lat++;
            end
            chk("rr_accept_seen", (req0_ready || req1_ready), 1);
            gid = req1_ready;
            acc = cyc;
            chk("rr_grant", gid, op % 2);
            if (op > 0) chk("rr_gap", acc - prev_acc, ALU_LAT + 3);
            prev_acc = acc;
            tick();
            await_rsp(lat);
            chk("rr_rsp_id", rsp_id, op % 2);
            chk("rr_rsp_data", rsp_data, (op % 2) ? 16'd5 : 16'd3);
            $display("op rr%0d grant=%0d rsp_id=%0d data=%0d", op, gid, rsp_id, rsp_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) tick();
        rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
